// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;

    // Counters must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of fetched instruction/PC pairs; clear empties it in one cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enq,
    input  logic                          deq,
    input  logic                          clear,
    input  ifu_entry_t                    wr_data,
    output ifu_entry_t                    rd_data,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    ifu_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !clear) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch front end: issues word fetches, buffers responses, flushes on redirect.
// Optional performance counters are built when IFU_PERF_EN is defined.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_flushed
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned IW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [IW-1:0]   inflight;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fire;
    logic            drop;
    logic            enq;
    logic            deq;
    logic [XLEN-1:0] target;
    logic [1:0]      unused_pc_lsb;
    ifu_entry_t      head;
    ifu_entry_t      wr_entry;

    assign target        = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_lsb = redirect_pc[1:0];

    // Buffered plus in-flight words never exceed DEPTH, so the FIFO cannot overflow.
    assign inflight       = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = reset & ~redirect_valid & (inflight < IW'(DEPTH));
    assign imem_req_addr  = imem_req_valid ? fetch_pc : '0;
    assign fire           = imem_req_valid & imem_req_ready;

    assign drop     = imem_rsp_valid & (redirect_valid | (discard != '0));
    assign enq      = imem_rsp_valid & ~drop;
    assign deq      = ~fifo_empty & inst_ready & ~redirect_valid;
    assign wr_entry = '{inst: imem_rsp_data, pc: pc_q};

    ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq     (enq),
        .deq     (deq),
        .clear   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign inst_valid = ~fifo_empty;
    assign inst       = fifo_empty ? INST_NOP : head.inst;
    assign inst_pc    = fifo_empty ? '0 : head.pc;

    // On redirect every request still in flight is stale, including a same-cycle response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            pc_q        <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= target;
                pc_q     <= target;
                discard  <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (fire) fetch_pc <= fetch_pc + 32'd4;
                if (enq)  pc_q     <= pc_q + 32'd4;
                if (drop) discard  <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && enq) assert (!fifo_full);
    end

`ifdef IFU_PERF_EN
    logic [XLEN-1:0] fetched_q;
    logic [XLEN-1:0] flushed_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_q + XLEN'(deq);
            flushed_q <= flushed_q + XLEN'(drop)
                       + (redirect_valid ? XLEN'(fifo_count) : '0);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`else
    assign perf_fetched = '0;
    assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomised bench for ifu_prefetch against a transaction-level fetch/memory model.
module tb_ifu_prefetch;
    import ifu_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;

    ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
    );

    always #5 clk = ~clk;

    // Memory request in flight: address, cycle its response appears, still wanted?
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] fq[$];
    logic [31:0] exp_fetch;
    logic [31:0] fetched_m;
    logic [31:0] flushed_m;
    int          cyc;
    int          lat;
    int          checks;
    int          errors;

    bit          s_req_valid, s_inst_valid, s_rsp, s_fire, s_deliver;
    logic [31:0] s_fire_addr, s_inst_pc, s_deliver_pc, s_perf_fetched, s_perf_flushed;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    // One clock: drive at negedge, compare against the model, advance model at posedge.
    task automatic step(input bit rq_rdy, input bit in_rdy, input bit redir, input logic [31:0] rpc);
        mreq_t e;
        bit    rsp, exp_rv, exp_iv;
        int    infl, due;
        @(negedge clk);
        rsp = 1'b0;
        e = '{addr: 32'h0, due: 0, live: 1'b0};
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            e = mq.pop_front();
            rsp = 1'b1;
        end
        reset          = 1'b1;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memword(e.addr) : $urandom;
        imem_req_ready = rq_rdy;
        inst_ready     = in_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        infl   = mq.size() + (rsp ? 1 : 0);
        exp_rv = (fq.size() + infl < int'(DEPTH)) && !redir;
        exp_iv = (fq.size() != 0);

        checks++;
        if (imem_req_valid !== exp_rv) begin
            errors++;
            $display("FAIL req_valid cyc=%0d got %b exp %b", cyc, imem_req_valid, exp_rv);
        end
        if (exp_rv) begin
            checks++;
            if (imem_req_addr !== exp_fetch) begin
                errors++;
                $display("FAIL req_addr cyc=%0d got %h exp %h", cyc, imem_req_addr, exp_fetch);
            end
        end
        checks++;
        if (inst_valid !== exp_iv) begin
            errors++;
            $display("FAIL inst_valid cyc=%0d got %b exp %b", cyc, inst_valid, exp_iv);
        end
        if (exp_iv) begin
            checks++;
            if (inst_pc !== fq[0] || inst !== memword(fq[0])) begin
                errors++;
                $display("FAIL head cyc=%0d got pc %h inst %h exp pc %h inst %h",
                         cyc, inst_pc, inst, fq[0], memword(fq[0]));
            end
        end
        checks++;
`ifdef IFU_PERF_EN
        if (perf_fetched !== fetched_m || perf_flushed !== flushed_m) begin
            errors++;
            $display("FAIL perf cyc=%0d got %0d/%0d exp %0d/%0d",
                     cyc, perf_fetched, perf_flushed, fetched_m, flushed_m);
        end
`else
        if (perf_fetched !== 32'h0 || perf_flushed !== 32'h0) begin
            errors++;
            $display("FAIL perf_off cyc=%0d got %h/%h exp 0/0", cyc, perf_fetched, perf_flushed);
        end
`endif

        s_req_valid    = imem_req_valid;
        s_inst_valid   = inst_valid;
        s_inst_pc      = inst_pc;
        s_rsp          = rsp;
        s_fire         = exp_rv && rq_rdy;
        s_fire_addr    = imem_req_addr;
        s_deliver      = exp_iv && in_rdy && !redir;
        s_deliver_pc   = inst_pc;
        s_perf_fetched = perf_fetched;
        s_perf_flushed = perf_flushed;

        if (redir) begin
            flushed_m += 32'(fq.size());
            fq.delete();
            foreach (mq[i]) mq[i].live = 1'b0;
        end else if (s_deliver) begin
            void'(fq.pop_front());
            fetched_m += 32'd1;
        end
        if (rsp) begin
            if (e.live && !redir) fq.push_back(e.addr);
            else flushed_m += 32'd1;
        end
        if (redir) begin
            exp_fetch = {rpc[31:2], 2'b00};
        end else if (s_fire) begin
            due = cyc + lat;
            if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
            mq.push_back('{addr: exp_fetch, due: due, live: 1'b1});
            exp_fetch += 32'd4;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset(input int n);
        mq.delete();
        fq.delete();
        exp_fetch = RPC;
        fetched_m = '0;
        flushed_m = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset          = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_req_ready = 1'($urandom);
            inst_ready     = 1'($urandom);
            redirect_valid = 1'($urandom);
            redirect_pc    = $urandom;
            #1;
            if (i > 0) begin
                checks++;
                if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_req got rv %b addr %h iv %b exp 0 0 0",
                             imem_req_valid, imem_req_addr, inst_valid);
                end
                checks++;
                if (inst !== 32'h0 || inst_pc !== 32'h0 || perf_fetched !== 32'h0 || perf_flushed !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_out got %h %h %h %h exp all 0",
                             inst, inst_pc, perf_fetched, perf_flushed);
                end
            end
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic test_basic();
        test_reset(2);
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if (!s_fire || s_fire_addr !== RPC + 32'(4 * i)) begin
                errors++;
                $display("FAIL basic_issue%0d got fire %b addr %h exp 1 %h", i, s_fire, s_fire_addr, RPC + 32'(4 * i));
            end
            checks++;
            if (s_inst_valid !== (i == 2) || (i == 2 && s_inst_pc !== RPC)) begin
                errors++;
                $display("FAIL basic_valid%0d got %b pc %h exp %b pc %h", i, s_inst_valid, s_inst_pc, i == 2, RPC);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        test_reset(2);
        lat = 1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (s_inst_valid !== 1'b1 || s_inst_pc !== RPC || s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_full got iv %b pc %h rv %b exp 1 %h 0", s_inst_valid, s_inst_pc, s_req_valid, RPC);
        end
        n = 0;
        for (int i = 0; i < 20 && n < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_deliver) begin
                checks++;
                if (s_deliver_pc !== RPC + 32'(4 * n)) begin
                    errors++;
                    $display("FAIL stall_drain%0d got %h exp %h", n, s_deliver_pc, RPC + 32'(4 * n));
                end
                n++;
            end
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL stall_timeout got %0d deliveries exp 6", n);
        end
    endtask

    task automatic test_redirect();
        bit got;
        logic [31:0] exp_fl, exp_ft;
        test_reset(2);
        lat = 3;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_3044);
        checks++;
        if (s_inst_valid !== 1'b1 || s_rsp !== 1'b1) begin
            errors++;
            $display("FAIL redir_setup got iv %b rsp %b exp 1 1", s_inst_valid, s_rsp);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (s_inst_valid !== 1'b0 || !s_fire || s_fire_addr !== 32'h0000_3044) begin
            errors++;
            $display("FAIL redir_first got iv %b fire %b addr %h exp 0 1 00003044", s_inst_valid, s_fire, s_fire_addr);
        end
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            got = s_deliver;
        end
        checks++;
        if (!got || s_deliver_pc !== 32'h0000_3044) begin
            errors++;
            $display("FAIL redir_deliver got %b pc %h exp 1 00003044", got, s_deliver_pc);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef IFU_PERF_EN
        exp_fl = 32'd4;
        exp_ft = 32'd1;
`else
        exp_fl = 32'd0;
        exp_ft = 32'd0;
`endif
        checks++;
        if (s_perf_flushed !== exp_fl || s_perf_fetched !== exp_ft) begin
            errors++;
            $display("FAIL redir_perf got %0d/%0d exp %0d/%0d", s_perf_fetched, s_perf_flushed, exp_ft, exp_fl);
        end
    endtask

    task automatic test_collide();
        bit got;
        test_reset(2);
        lat = 1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_3200);
        checks++;
        if (s_rsp !== 1'b1 || s_inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL collide_setup got rsp %b iv %b exp 1 1", s_rsp, s_inst_valid);
        end
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            got = s_deliver;
        end
        checks++;
        if (!got || s_deliver_pc !== 32'h0000_3200) begin
            errors++;
            $display("FAIL collide_next got %b pc %h exp 1 00003200", got, s_deliver_pc);
        end
    endtask

    task automatic test_back_to_back();
        bit got_f, got_d;
        for (int g = 0; g < 2; g++) begin
            test_reset(2);
            lat = 2;
            for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
            step(1'b1, 1'b1, 1'b1, 32'h0000_3047);
            if (g == 1) begin
                step(1'b1, 1'b1, 1'b0, 32'h0);
                checks++;
                if (!s_fire || s_fire_addr !== 32'h0000_3044) begin
                    errors++;
                    $display("FAIL b2b_mid got fire %b addr %h exp 1 00003044", s_fire, s_fire_addr);
                end
            end
            step(1'b1, 1'b1, 1'b1, 32'h0000_3100);
            checks++;
            if (s_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gate%0d got %b exp 0", g, s_req_valid);
            end
            got_f = 1'b0;
            got_d = 1'b0;
            for (int i = 0; i < 30 && !got_d; i++) begin
                step(1'b1, 1'b1, 1'b0, 32'h0);
                if (s_fire && !got_f) begin
                    got_f = 1'b1;
                    checks++;
                    if (s_fire_addr !== 32'h0000_3100) begin
                        errors++;
                        $display("FAIL b2b_issue%0d got %h exp 00003100", g, s_fire_addr);
                    end
                end
                got_d = s_deliver;
            end
            checks++;
            if (!got_d || s_deliver_pc !== 32'h0000_3100) begin
                errors++;
                $display("FAIL b2b_deliver%0d got %b pc %h exp 1 00003100", g, got_d, s_deliver_pc);
            end
        end
    endtask

    task automatic test_mid_reset();
        test_reset(2);
        lat = 2;
        for (int i = 0; i < 25; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 1'b0, 32'h0);
        test_reset(2);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (s_req_valid !== 1'b1 || s_fire_addr !== RPC || s_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got rv %b addr %h iv %b exp 1 %h 0", s_req_valid, s_fire_addr, s_inst_valid, RPC);
        end
    endtask

    task automatic test_random();
        int  n_del;
        bit  redir;
        test_reset(2);
        lat = 1;
        n_del = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) lat = $urandom_range(1, 4);
            redir = ($urandom_range(0, 31) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, redir, $urandom);
            if (s_deliver) n_del++;
        end
        checks++;
        if (n_del < 200) begin
            errors++;
            $display("FAIL random_progress got %0d deliveries exp >=200", n_del);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        lat = 1;
        reset = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        test_reset(3);
        test_basic();
        test_stall();
        test_redirect();
        test_collide();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
